// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for the Flappy Bird playfield.
//   Runs the IDLE/ARM/PLAY/OVER game state machine and divides the clock into
//   game-step ticks. Between ticks it latches flap edges. On each tick it checks
//   for bird/pipe and floor collisions. It keeps a two-digit BCD score and the
//   best score seen since reset.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   start      debounced start button (rising edge used)
//   flap       debounced flap button (rising edge used)
//   bird_row   one-hot bird row, bit 0 = floor row
//   pipe_col   wall bits of the column the bird occupies
//   floor_hit  bird datapath reports a floor landing
//   tick       one-cycle game-step pulse
//   flap_req   flap command, valid while tick=1
//   game_reset one-cycle datapath reinit pulse (ARM)
//   playing    high in PLAY
//   game_over  high in OVER
//   score      current BCD score {tens, units}
//   hi_score   best BCD score since reset
module game_ctrl #(
  parameter int unsigned TICK_DIV    = 192,
  parameter int unsigned GRACE_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       flap,
  input  logic [7:0] bird_row,
  input  logic [7:0] pipe_col,
  input  logic       floor_hit,
  output logic       tick,
  output logic       flap_req,
  output logic       game_reset,
  output logic       playing,
  output logic       game_over,
  output logic [7:0] score,
  output logic [7:0] hi_score
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_OVER
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(TICK_DIV - 1);
  localparam logic [3:0] GRACE_INIT = 4'(GRACE_TICKS);

  state_t     state_q, state_d;
  logic       start_q, flap_q;
  logic [7:0] div_q, div_d;
  logic [3:0] grace_q, grace_d;
  logic       pend_q, pend_d;
  logic [7:0] score_q, score_d;
  logic [7:0] hi_q, hi_d;

  logic start_rise, flap_rise, hit;

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) begin
      return v;
    end
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign start_rise = start & ~start_q;
  assign flap_rise  = flap & ~flap_q;
  assign hit        = (|(bird_row & pipe_col)) | floor_hit;

  assign tick       = (state_q == S_PLAY) && (div_q == DIV_LAST);
  // An edge landing on the tick cycle itself is consumed by that tick.
  assign flap_req   = tick & (pend_q | flap_rise);
  assign game_reset = (state_q == S_ARM);
  assign playing    = (state_q == S_PLAY);
  assign game_over  = (state_q == S_OVER);
  assign score      = score_q;
  assign hi_score   = hi_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    grace_d = grace_q;
    pend_d  = 1'b0;
    score_d = score_q;
    hi_d    = hi_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise) state_d = S_ARM;
      end
      S_ARM: begin
        div_d   = '0;
        grace_d = GRACE_INIT;
        score_d = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (tick) begin
          div_d = '0;
          if (grace_q != '0) begin
            grace_d = grace_q - 4'd1;
          end else if (hit) begin
            state_d = S_OVER;
            if (score_q > hi_q) hi_d = score_q;
          end else if (pipe_col != '0) begin
            score_d = bcd_inc(score_q);
          end
        end else begin
          div_d  = div_q + 8'd1;
          pend_d = pend_q | flap_rise;
        end
      end
      S_OVER: begin
        if (start_rise) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edge-detect registers reset to 1 so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;
      flap_q  <= 1'b1;
      div_q   <= '0;
      grace_q <= '0;
      pend_q  <= 1'b0;
      score_q <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      flap_q  <= flap;
      div_q   <= div_d;
      grace_q <= grace_d;
      pend_q  <= pend_d;
      score_q <= score_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: a cycle-level reference model compares
// every output on every cycle. Directed sequences, a collision vector table and
// a randomized phase supply the stimulus.
module tb_game_ctrl;

  localparam int unsigned TD = 192;
  localparam int unsigned GR = 2;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_PLAY = 2;
  localparam int M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b1;
  logic       flap = 1'b0;
  logic       floor_hit = 1'b0;
  logic [7:0] bird_row = 8'h01;
  logic [7:0] pipe_col = 8'h00;
  logic       tick, flap_req, game_reset, playing, game_over;
  logic [7:0] score, hi_score;

  int checks = 0;
  int errors = 0;

  // Reference model: game phase, cycles since ARM, ticks since ARM, decimal scores.
  int m_mode, m_cyc, m_ticks, m_score, m_hi;
  bit m_pend, m_ps, m_pf;

  bit last_tick, last_freq;
  int freq_count = 0;

  typedef struct {
    logic [7:0] bird;
    logic [7:0] pipe;
    logic       flr;
    logic       exp_over;
    logic [7:0] exp_score;
  } coll_vec_t;

  game_ctrl #(.TICK_DIV(TD), .GRACE_TICKS(GR)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flap      (flap),
    .bird_row  (bird_row),
    .pipe_col  (pipe_col),
    .floor_hit (floor_hit),
    .tick      (tick),
    .flap_req  (flap_req),
    .game_reset(game_reset),
    .playing   (playing),
    .game_over (game_over),
    .score     (score),
    .hi_score  (hi_score)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cyc = 0; m_ticks = 0; m_score = 0; m_hi = 0;
    m_pend = 1'b0; m_ps = 1'b1; m_pf = 1'b1;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    logic        exp_tick, srise, frise, hit;
    logic [28:0] exp_v, act_v;
    @(negedge clk);
    exp_tick = (m_mode == M_PLAY) && (m_cyc % TD == 0);
    srise    = start && !m_ps;
    frise    = flap && !m_pf;
    hit      = ((bird_row & pipe_col) != 8'h00) || floor_hit;
    exp_v = {exp_tick, exp_tick && (m_pend || frise), m_mode == M_ARM, m_mode == M_PLAY,
             m_mode == M_OVER, to_bcd(m_score), to_bcd(m_hi)};
    act_v = {tick, flap_req, game_reset, playing, game_over, score, hi_score};
    chk("model", 32'(act_v), 32'(exp_v));
    last_tick = tick;
    last_freq = flap_req;
    if (flap_req) freq_count++;
    case (m_mode)
      M_IDLE: if (srise) m_mode = M_ARM;
      M_ARM: begin
        m_mode = M_PLAY; m_cyc = 1; m_ticks = 0; m_pend = 1'b0; m_score = 0;
      end
      M_PLAY: begin
        if (exp_tick) begin
          if (m_ticks >= int'(GR)) begin
            if (hit) begin
              m_mode = M_OVER;
              if (m_score > m_hi) m_hi = m_score;
            end else if (pipe_col != 8'h00 && m_score < 99) begin
              m_score++;
            end
          end
          m_ticks++;
          m_pend = 1'b0;
        end else if (frise) begin
          m_pend = 1'b1;
        end
        m_cyc++;
      end
      default: if (srise) m_mode = M_ARM;
    endcase
    m_ps = start;
    m_pf = flap;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    last_tick = 1'b0;
    while (!last_tick && n < int'(TD) + 4) begin
      step();
      n++;
    end
    if (!last_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout actual=no_tick required=tick within %0d cycles", TD + 4);
    end
  endtask

  task automatic arm_game();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("arm_pulse", 32'(game_reset), 32'd1);
    step();
    chk("play_after_arm", 32'({playing, game_reset}), 32'b10);
  endtask

  initial begin
    int n;
    coll_vec_t cv[6];
    logic [7:0] exp_sc[12];

    cv[0] = '{bird: 8'h10, pipe: 8'h10, flr: 1'b0, exp_over: 1'b1, exp_score: 8'h00};
    cv[1] = '{bird: 8'h01, pipe: 8'h00, flr: 1'b1, exp_over: 1'b1, exp_score: 8'h00};
    cv[2] = '{bird: 8'h80, pipe: 8'h7F, flr: 1'b0, exp_over: 1'b0, exp_score: 8'h01};
    cv[3] = '{bird: 8'h02, pipe: 8'h00, flr: 1'b0, exp_over: 1'b0, exp_score: 8'h00};
    cv[4] = '{bird: 8'h01, pipe: 8'h01, flr: 1'b0, exp_over: 1'b1, exp_score: 8'h00};
    cv[5] = '{bird: 8'h40, pipe: 8'hE0, flr: 1'b0, exp_over: 1'b1, exp_score: 8'h00};
    exp_sc = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
               8'h10, 8'h11, 8'h12};

    // Reset with start held high.
    model_reset();
    #1 reset = 1'b0;
    #11;
    chk("reset_state", 32'({tick, flap_req, game_reset, playing, game_over, score, hi_score}), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    steps(5);
    chk("no_arm_while_held", 32'({game_reset, playing}), 32'd0);

    // Arm, first tick latency, flap latching.
    arm_game();
    wait_tick(n);
    chk("first_tick_latency", 32'(n), 32'(TD));
    freq_count = 0;
    steps(9);
    flap = 1'b1; step(); flap = 1'b0;
    steps(39);
    flap = 1'b1; step(); flap = 1'b0;
    wait_tick(n);
    chk("tick_spacing", 32'(n), 32'(TD - 50));
    chk("flap_req_two_edges", 32'(last_freq), 32'd1);
    steps(int'(TD) - 1);
    flap = 1'b1; step();
    chk("flap_on_tick", 32'({last_tick, last_freq}), 32'b11);
    flap = 1'b0;
    wait_tick(n);
    chk("flap_consumed", 32'(last_freq), 32'd0);
    chk("flap_pulse_count", 32'(freq_count), 32'd2);
    floor_hit = 1'b1;
    wait_tick(n);
    chk("floor_over", 32'({game_over, playing}), 32'b10);
    floor_hit = 1'b0;

    // Grace: overlap held from the start, only the third tick is fatal.
    bird_row = 8'h10; pipe_col = 8'h10;
    arm_game();
    wait_tick(n);
    chk("grace_tick1", 32'({playing, score}), 32'h100);
    wait_tick(n);
    chk("grace_tick2", 32'({playing, score}), 32'h100);
    wait_tick(n);
    chk("grace_tick3_over", 32'({game_over, playing}), 32'b10);
    chk("grace_scores", 32'({score, hi_score}), 32'h0000);

    // BCD scoring sequence and high score.
    bird_row = 8'h10; pipe_col = 8'h81;
    arm_game();
    wait_tick(n);
    wait_tick(n);
    chk("grace_no_score", 32'(score), 32'h00);
    for (int i = 0; i < 12; i++) begin
      wait_tick(n);
      chk($sformatf("score_step%0d", i + 1), 32'(score), 32'(exp_sc[i]));
    end
    floor_hit = 1'b1;
    wait_tick(n);
    floor_hit = 1'b0;
    chk("hi_after_12", 32'({game_over, score, hi_score}), 32'h11212);

    arm_game();
    chk("score_cleared", 32'(score), 32'h00);
    for (int i = 0; i < int'(GR) + 5; i++) wait_tick(n);
    floor_hit = 1'b1;
    wait_tick(n);
    floor_hit = 1'b0;
    chk("hi_kept", 32'({game_over, score, hi_score}), 32'h10512);

    // Collision vector table, applied on the first post-grace tick.
    foreach (cv[k]) begin
      bird_row = 8'h01; pipe_col = 8'h00; floor_hit = 1'b0;
      arm_game();
      wait_tick(n);
      wait_tick(n);
      bird_row = cv[k].bird; pipe_col = cv[k].pipe; floor_hit = cv[k].flr;
      wait_tick(n);
      chk($sformatf("coll%0d_over", k), 32'(game_over), 32'(cv[k].exp_over));
      chk($sformatf("coll%0d_score", k), 32'(score), 32'(cv[k].exp_score));
      if (!game_over) begin
        bird_row = 8'h01; pipe_col = 8'h00; floor_hit = 1'b1;
        wait_tick(n);
        chk($sformatf("coll%0d_end", k), 32'(game_over), 32'd1);
      end
    end
    floor_hit = 1'b0;

    // Saturation at 99.
    bird_row = 8'h10; pipe_col = 8'h81;
    arm_game();
    for (int i = 0; i < int'(GR); i++) wait_tick(n);
    for (int i = 1; i <= 120; i++) begin
      wait_tick(n);
      if (i == 98) chk("sat_98", 32'(score), 32'h98);
      if (i == 99) chk("sat_99", 32'(score), 32'h99);
    end
    chk("sat_hold", 32'(score), 32'h99);
    floor_hit = 1'b1;
    wait_tick(n);
    floor_hit = 1'b0;
    chk("hi_99", 32'(hi_score), 32'h99);

    // Asynchronous reset in the middle of PLAY.
    arm_game();
    steps(50);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_out",
        32'({tick, flap_req, game_reset, playing, game_over, score, hi_score}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    steps(3);
    chk("idle_after_reset", 32'({game_reset, playing, game_over}), 32'd0);

    // Randomized play checked against the model.
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 7) == 0) flap = ~flap;
      if ($urandom_range(0, 19) == 0) start = ~start;
      bird_row  = 8'(1 << $urandom_range(0, 7));
      pipe_col  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      floor_hit = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
